// File: rtl/pong_pkg.sv
// Shared constants for the pong front end: button count, button bit indices, default debounce length.
// Pure declarations; no logic, no latency, no flow control.
package pong_pkg;

  localparam int N_BTN = 5;

  localparam int BTN_P1_UP = 0;
  localparam int BTN_P1_DN = 1;
  localparam int BTN_P2_UP = 2;
  localparam int BTN_P2_DN = 3;
  localparam int BTN_START = 4;

  // About 10 ms at a 33.3 MHz pixel clock.
  localparam int DEBOUNCE_CYCLES_DEF = 333_000;

endpackage

// File: rtl/debounce_channel.sv
// One button: synchroniser, stability counter, debounced active-low level and registered press/release strobes.
// Level follows raw after SYNC_STAGES+DEBOUNCE_CYCLES-1 edges, strobes one edge later; no backpressure.
module debounce_channel
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic level_n,
  output logic press_stb,
  output logic release_stb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic                   level_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_n};
    end
  end

  // Any cycle of agreement restarts the count, so bounces never accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      level_n <= 1'b1;
    end else if (sync == level_n) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt     <= '0;
      level_n <= sync;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d     <= 1'b1;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
    end else begin
      level_d     <= level_n;
      press_stb   <= level_d & ~level_n;
      release_stb <= ~level_d & level_n;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces the five active-low board buttons, one independent channel per bit.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES-1 edges to btn_n, strobes one edge later; no backpressure.
module button_conditioner
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             P_CLK,
  input  logic             NRST,
  input  logic [N_BTN-1:0] btn_raw_n,
  output logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_chan (
      .clk        (P_CLK),
      .rst_n      (NRST),
      .raw_n      (btn_raw_n[i]),
      .level_n    (btn_n[i]),
      .press_stb  (btn_press[i]),
      .release_stb(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed plus randomised bench for button_conditioner against a sliding-window reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_button_conditioner;
  import pong_pkg::*;

  localparam int DEB = 4;
  localparam int SS  = 2;

  logic       clk  = 1'b0;
  logic       nrst = 1'b1;
  logic [4:0] raw  = 5'h1F;
  logic [4:0] btn_n, press, rel;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SS)
  ) dut (
    .P_CLK      (clk),
    .NRST       (nrst),
    .btn_raw_n  (raw),
    .btn_n      (btn_n),
    .btn_press  (press),
    .btn_release(rel)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: raw value seen at every edge since reset release, plus the expected outputs.
  logic [4:0] hist[$];
  logic [4:0] m_lvl, m_press, m_rel, m_fall, m_rise;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_lvl   = 5'h1F;
    m_press = '0;
    m_rel   = '0;
    m_fall  = '0;
    m_rise  = '0;
  endtask

  // Value at the end of the synchroniser just before edge j (all ones until the chain fills).
  function automatic logic [4:0] sync_before(input int j);
    if (j - SS < 0) return 5'h1F;
    return hist[j-SS];
  endfunction

  // A level flips at edge e when the synchronised input disagreed with it before each of the last DEB edges.
  task automatic model_edge();
    int         e;
    logic [4:0] flip;
    e       = hist.size();
    m_press = m_fall;
    m_rel   = m_rise;
    flip    = 5'h1F;
    if (e < DEB - 1) flip = '0;
    else for (int j = e - DEB + 1; j <= e; j++) flip &= sync_before(j) ^ m_lvl;
    m_fall = flip & m_lvl;
    m_rise = flip & ~m_lvl;
    m_lvl  = m_lvl ^ flip;
    hist.push_back(raw);
  endtask

  // Called on a falling edge: drive, let one rising edge pass, compare, return on the next falling edge.
  task automatic cycle(input logic [4:0] v);
    raw = v;
    @(posedge clk);
    model_edge();
    #1;
    check("btn_n", btn_n, m_lvl);
    check("btn_press", press, m_press);
    check("btn_release", rel, m_rel);
    check("press_and_release", press & rel, 5'b00000);
    @(negedge clk);
  endtask

  task automatic hold(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(v);
  endtask

  // Asserts reset away from any clock edge, checks the asynchronous clear, releases on a falling edge.
  task automatic do_reset(input logic [4:0] v, input int n);
    raw  = v;
    #2;
    nrst = 1'b0;
    #1;
    model_reset();
    check("rst_btn_n", btn_n, 5'h1F);
    check("rst_press", press, 5'b00000);
    check("rst_release", rel, 5'b00000);
    for (int i = 0; i < n; i++) @(negedge clk);
    nrst = 1'b1;
  endtask

  function automatic logic [4:0] low_bit(input int b);
    logic [4:0] one;
    one = 5'b00001;
    return ~(one << b);
  endfunction

  initial begin
    int         hold_cnt[5];
    logic [4:0] v;

    @(negedge clk);
    // All buttons held through reset: pressed at edge 5 after release, one press strobe each.
    do_reset(5'b00000, 2);
    hold(5'b00000, 8);
    hold(5'h1F, 8);

    // Clean press and release of p1_up.
    hold(low_bit(BTN_P1_UP), 8);
    hold(5'h1F, 8);

    // Bouncing start button never settles long enough.
    hold(low_bit(BTN_START), 3);
    hold(5'h1F, 1);
    hold(low_bit(BTN_START), 3);
    hold(5'h1F, 8);

    // p2_dn press then release.
    hold(low_bit(BTN_P2_DN), 8);
    hold(5'h1F, 8);

    // p1_dn and p2_up together, p2_up let go early.
    hold(low_bit(BTN_P1_DN) & low_bit(BTN_P2_UP), 2);
    hold(low_bit(BTN_P1_DN), 8);
    hold(5'h1F, 8);

    // Reset in the middle of a count, button kept down.
    hold(low_bit(BTN_P1_UP), 3);
    do_reset(low_bit(BTN_P1_UP), 2);
    hold(low_bit(BTN_P1_UP), 8);
    hold(5'h1F, 8);

    // Random per-channel hold times straddling the debounce length, with occasional resets.
    for (int c = 0; c < 5; c++) hold_cnt[c] = 0;
    v = 5'h1F;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 5; c++) begin
        if (hold_cnt[c] == 0) begin
          if ($urandom_range(0, 1) == 1) v[c] = ~v[c];
          hold_cnt[c] = $urandom_range(1, 2 * DEB + 3);
        end else begin
          hold_cnt[c]--;
        end
      end
      cycle(v);
      if (n == 500 || n == 1100) do_reset(v, $urandom_range(1, 3));
    end
    hold(5'h1F, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage between the five raw board buttons and the pong game driver. It synchronises each asynchronous, active-low push-button input to the pixel clock and debounces it with a per-channel stability counter. For each button it provides a clean active-low level, which is the form the driver's `p1_up`/`p1_dn`/`p2_up`/`p2_dn`/`start` inputs consume, plus single-cycle press and release strobes.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 333_000: consecutive cycles a synchronised input must differ from the debounced level before the level flips (≈10 ms at 33.3 MHz). Legal range is 2 .. 2^24−1.
- `SYNC_STAGES`, default 2: depth of the synchroniser flop chain. Legal range is 2..4.

Ports (clock and reset first):
- `P_CLK`  in  1: pixel clock, the only clock.
- `NRST`  in  1: asynchronous, active-low reset.
- `btn_raw_n`  in  5: raw buttons, active-low, idle high. Bit order is {start, p2_dn, p2_up, p1_dn, p1_up} (bit 4..0).
- `btn_n`  out  5: debounced level, active-low, same bit order. Feeds the driver directly.
- `btn_press`  out  5: 1-cycle high strobe when a `btn_n` bit goes 1→0.
- `btn_release`  out  5: 1-cycle high strobe when a `btn_n` bit goes 0→1.

## Operation
- There are five identical, fully independent channels. No channel's behaviour depends on another.
- Synchroniser: a `SYNC_STAGES`-deep flop chain on `btn_raw_n[i]`. Only the last stage (`sync[i]`) is used downstream.
- Debounce counter `cnt[i]`:
  - Width is `$clog2(DEBOUNCE_CYCLES)`, unsigned.
  - If `sync[i] == btn_n[i]`, `cnt[i]` is cleared to 0.
  - If `sync[i] != btn_n[i]` and `cnt[i] < DEBOUNCE_CYCLES−1`, `cnt[i]` increments.
  - If `sync[i] != btn_n[i]` and `cnt[i] == DEBOUNCE_CYCLES−1`, then `btn_n[i] <= sync[i]` and `cnt[i] <= 0`.
- Consequences of the counter rule:
  - The counter never wraps.
  - Any single cycle of agreement (a bounce) restarts the count from 0.
- Strobes are registered:
  - `btn_press[i]` is high for exactly the one cycle after `btn_n[i]` transitions 1→0.
  - `btn_release[i]` is high for exactly the one cycle after `btn_n[i]` transitions 0→1.
  - Press and release can never both be high for the same channel in the same cycle.
  - Any number of channels may strobe in the same cycle.
- Reset values, applied asynchronously on `NRST` low:
  - All synchroniser flops = 1.
  - `btn_n` = 5'b11111 (released).
  - `cnt` = 0.
  - `btn_press` = 0 and `btn_release` = 0.
- Reset release:
  - The first cycle after `NRST` rises behaves as idle.
  - A button held down through reset is reported pressed after the normal latency, counted from reset release, and produces a press strobe.
- Reset asserted mid-count abandons the count. No strobe is emitted.

## Timing
- Let raw be stable at a new value before sampling edge k.
- `sync` reflects the new value after edge k+SYNC_STAGES−1.
- `btn_n` changes after edge k+SYNC_STAGES+DEBOUNCE_CYCLES−1. With defaults this is k+333_001.
- The strobe is high in the cycle following the `btn_n` change.
- Glitch rejection: any excursion shorter than `DEBOUNCE_CYCLES` synchronised cycles never reaches `btn_n`.
- Throughput: a full press→release→press sequence needs at least 2·`DEBOUNCE_CYCLES` cycles.
- No combinational path from any input to any output.

## Structure
- Shared package `pong_pkg`:
  - `N_BTN` = 5.
  - Button index constants `BTN_P1_UP`=0, `BTN_P1_DN`=1, `BTN_P2_UP`=2, `BTN_P2_DN`=3, `BTN_START`=4.
  - Default `DEBOUNCE_CYCLES`.
  - The driver uses the same index constants.
- One sub-module, `debounce_channel`:
  - Contains the synchroniser, counter, level register and strobe registers for one bit.
  - Parameterised identically to the top level.
  - Instantiated `N_BTN` times via generate.
- Top level contains only the generate loop and port packing.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `SYNC_STAGES`=2.
- Reset check: `NRST`=0 with `btn_raw_n`=5'b00000 → `btn_n`=5'b11111 and strobes=0 immediately (asynchronous). After release, `btn_n`=5'b00000 at edge 5, and `btn_press`=5'b11111 for exactly one cycle.
- Clean press of p1_up: drop bit 0 before edge k, hold → `btn_n[0]` low after edge k+5, `btn_press[0]`=1 only in the next cycle, and all other bits stay 1/0.
- Bounce rejection: on bit 4, drive low 3 cycles, high 1, low 3, high → `btn_n[4]` stays 1 and no strobes.
- Release: holding bit 3 low, raise it and hold → `btn_n[3]` high after edge k+5 and `btn_release[3]` pulses once. Press and release are never both high.
- Simultaneous channels: bits 1 and 2 pressed on the same edge, bit 2 released 2 cycles later, bit 1 held → bit 1 press strobe at the expected edge, bit 2 never changes.
- Reset mid-count: press bit 0, assert `NRST` after 3 cycles, deassert, keep pressed → no strobe before reset. Press is reported at edge 5 after release with exactly one `btn_press[0]` pulse.
